// File: rtl/cover_toggle_collector.sv
// cover_toggle_collector
// ----------------------
// Receiving end of the toggle-coverage report interface. Every cycle it samples
// the hit vector driven by the toggle coverage points, keeps a sticky record of
// which points have ever been hit, and emits each newly covered point exactly
// once as an absolute cover index on a valid/ready output stream. A running
// count of emitted points and an "everything covered" flag are maintained.
//
// Ports:
//   clock         in   single clock, rising edge
//   reset         in   asynchronous active-low reset
//   enable        in   hit sampling enable (hits ignored when 0)
//   valid         in   [WIDTH-1:0] per-point hit strobes
//   clear         in   synchronous request to forget all coverage
//   out_valid     out  out_index holds a newly covered point
//   out_ready     in   sink accepts out_index this cycle
//   out_index     out  [63:0] absolute cover index (COVER_INDEX + bit)
//   covered_count out  points emitted since reset/clear
//   all_covered   out  every point has been emitted
//   debug_state   out  [1:0] FSM state (0 IDLE, 1 SEND, 2 CLEARING)
//
// Output handshake: a transfer happens on a rising edge where out_valid and
// out_ready are both 1. While out_valid=1 and out_ready=0, out_index and
// out_valid hold stable. out_valid never depends combinationally on out_ready.
// The only exception is clear/reset, which withdraw an un-accepted index.

module cover_toggle_collector #(
  parameter int unsigned WIDTH       = 65,
  parameter int unsigned COVER_INDEX = 0,
  parameter int unsigned COVER_TOTAL = 38253
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [WIDTH-1:0]             valid,
  input  logic                         clear,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [63:0]                  out_index,
  output logic [$clog2(WIDTH+1)-1:0]   covered_count,
  output logic                         all_covered,
  output logic [1:0]                   debug_state
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned SW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  // The absolute index range must fit inside the design's point count.
  if (64'(COVER_INDEX) + 64'(WIDTH) > 64'(COVER_TOTAL)) begin : g_range_bad
    $error("cover_toggle_collector: COVER_INDEX+WIDTH exceeds COVER_TOTAL");
  end

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND     = 2'd1,
    CLEARING = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] seen_q, pending_q;
  logic [WIDTH-1:0] hit, new_hit, pend_merged;
  logic [WIDTH-1:0] sel_src, sel_mask;
  logic [SW-1:0]    sel;
  logic             sample, fire;
  logic             load, out_valid_d, count_inc, drop_all;
  logic [CW-1:0]    count_d;

  // Hits are dropped on the clear cycle and throughout CLEARING.
  assign sample      = enable && !clear && (state_q != CLEARING);
  assign hit         = sample ? valid : '0;
  assign new_hit     = hit & ~seen_q;
  assign pend_merged = pending_q | new_hit;
  assign fire        = (state_q == SEND) && out_ready;

  // From IDLE only registered pending bits are eligible (two-cycle hit
  // latency); in SEND bits arriving this cycle can be chained back-to-back.
  assign sel_src  = (state_q == SEND) ? pend_merged : pending_q;
  // Two's-complement trick isolates the lowest set bit.
  assign sel_mask = sel_src & (~sel_src + WIDTH'(1));

  always_comb begin
    sel = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (sel_src[i]) sel = SW'(i);
    end
  end

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = CLEARING;
    end else begin
      case (state_q)
        IDLE:     if (|pending_q) state_d = SEND;
        SEND:     if (fire && !(|pend_merged)) state_d = IDLE;
        CLEARING: state_d = IDLE;
        default:  state_d = IDLE;
      endcase
    end
  end

  // Output / control logic
  always_comb begin
    load        = 1'b0;
    out_valid_d = out_valid;
    count_inc   = 1'b0;
    drop_all    = 1'b0;
    if (clear) begin
      out_valid_d = 1'b0;
      drop_all    = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          out_valid_d = 1'b0;
          if (|pending_q) begin
            load        = 1'b1;
            out_valid_d = 1'b1;
          end
        end
        SEND: begin
          if (fire) begin
            count_inc = 1'b1;
            if (|pend_merged) load = 1'b1;
            else              out_valid_d = 1'b0;
          end
        end
        CLEARING: begin
          out_valid_d = 1'b0;
          drop_all    = 1'b1;
        end
        default: out_valid_d = 1'b0;
      endcase
    end
  end

  assign count_d = count_inc ? covered_count + CW'(1) : covered_count;

  // Datapath registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      seen_q        <= '0;
      pending_q     <= '0;
      out_valid     <= 1'b0;
      out_index     <= '0;
      covered_count <= '0;
      all_covered   <= 1'b0;
    end else if (drop_all) begin
      seen_q        <= '0;
      pending_q     <= '0;
      out_valid     <= 1'b0;
      covered_count <= '0;
      all_covered   <= 1'b0;
    end else begin
      seen_q        <= seen_q | hit;
      pending_q     <= pend_merged & ~(load ? sel_mask : '0);
      out_valid     <= out_valid_d;
      if (load) out_index <= 64'(COVER_INDEX) + 64'(sel);
      covered_count <= count_d;
      all_covered   <= (count_d == CW'(WIDTH));
    end
  end

  assign debug_state = state_q;

endmodule

// File: doc/cover_toggle_collector.md
Name: cover_toggle_collector

Overview:
- Receiving end of the toggle-coverage report interface: consumes the per-cycle hit vector that toggle coverage points drive.
- Keeps a sticky record of which points have been hit.
- Emits each newly covered point exactly once as an absolute cover index on a valid/ready stream.
- Sits between the toggle coverage points and the coverage sink (DPI bridge or on-chip coverage buffer); also keeps a running covered count.

Parameters:
- WIDTH, 65, number of toggle points in the hit vector.
- COVER_INDEX, 0, absolute index of bit 0; bit i reports COVER_INDEX+i.
- COVER_TOTAL, 38253, total points in the design; bounds COVER_INDEX+WIDTH.

Ports:
- clock  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- enable  input  1  hit sampling enable; hits ignored when 0.
- valid  input  WIDTH  per-point hit strobes, sampled every cycle.
- clear  input  1  synchronous request to forget all coverage.
- out_valid  output  1  out_index holds a newly covered point.
- out_ready  input  1  sink accepts out_index this cycle.
- out_index  output  64  absolute cover index (COVER_INDEX+i).
- covered_count  output  clog2(WIDTH+1)  number of points emitted since reset/clear.
- all_covered  output  1  every point has been emitted.

Behaviour:
- Reset (asynchronous, reset==0): seen, pending, out_valid, out_index, covered_count and all_covered all go to 0. State = IDLE.
- Sampling, every cycle with enable=1 and clear=0:
  - new = valid & ~seen
  - seen |= valid
  - pending |= new
  - A bit already in seen never re-enters pending, so each point is reported once.
- enable=0: valid is ignored entirely; pending draining continues.
- Selection: the lowest-indexed set bit of pending. Fixed priority; no round-robin.
- FSM states:
  - IDLE: out_valid=0. If pending≠0 and no clear, load out_index = COVER_INDEX + sel, clear pending[sel], set out_valid, go to SEND.
  - SEND: out_valid=1; out_index and out_valid are held stable while out_ready=0. On out_ready=1 (fire): covered_count+1. Then:
    - if pending (including bits set this cycle) ≠ 0, load the next lowest index the same cycle and stay in SEND, giving back-to-back output at 1/cycle;
    - else clear out_valid and go to IDLE.
  - CLEARING: entered from any state when clear=1. out_valid=0 next cycle; seen, pending and covered_count go to 0. Return to IDLE the following cycle.
    - Hits presented during the clear cycle and the CLEARING cycle are dropped.
    - clear aborts an un-accepted SEND; the aborted index is not counted.
- Latency: a hit at cycle t gives out_valid at t+2 if the FSM is IDLE and lower-indexed pending bits are absent.
- A same-cycle hit on the bit being loaded is already in seen and is ignored.
- A hit on a bit pending but not yet emitted is absorbed (no duplicate).
- covered_count saturates logically at WIDTH; it cannot exceed WIDTH by construction.
- all_covered is registered: 1 when covered_count==WIDTH. Cleared by reset or clear.
- out_index is 64-bit unsigned; COVER_INDEX+i must not wrap (COVER_INDEX+WIDTH ≤ COVER_TOTAL is checked by elaboration assert).
- Reset asserted mid-SEND: outputs drop asynchronously and nothing is counted. After release, hits must recur to be reported.

Test Plan:
- Reset released, enable=1, valid=65'h1 at cycle 3, out_ready=1 → out_valid=1 at cycle 5 with out_index=COVER_INDEX; covered_count=1 at cycle 6; a second valid[0] pulse produces no output.
- valid bits 2, 7 and 64 set in one cycle, out_ready=1 → indices COVER_INDEX+2, +7, +64 on three consecutive cycles; covered_count=3.
- Bit 5 hit, out_ready held 0 for 4 cycles while bit 1 is hit → out_index stays COVER_INDEX+5 for all 4 cycles; after the fire, COVER_INDEX+1 follows next cycle.
- All 65 bits hit once with out_ready toggling 1/0 → 65 unique indices in ascending order; covered_count=65; all_covered=1 one cycle after the last fire.
- clear asserted while in SEND with out_ready=0 → out_valid=0 next cycle; covered_count=0; the same bit hit again afterwards is re-reported.
- reset pulled low mid-SEND at an arbitrary phase → outputs 0 immediately (asynchronous); enable=0 with valid all-ones → no output and covered_count stays 0.
